// File: rtl/bist_pkg.sv
// rtl/bist_pkg.sv - shared state encoding and MISR step function for the BIST sequencer
package bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CUT_RST,
        FETCH,
        APPLY,
        CAPTURE,
        DONE
    } state_t;

    localparam logic [13:0] MISR_POLY_DEFAULT = 14'h2C01;

    // One MISR step on the low `width` bits: shift left, fold the msb back through poly, xor in d.
    function automatic logic [31:0] misr_step(input logic [31:0] m, input logic [31:0] d,
                                              input logic [31:0] poly, input int width);
        logic [31:0] mask;
        logic [31:0] r;
        mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        r = {m[30:0], 1'b0};
        if (((m >> (width - 1)) & 32'd1) != 32'd0) begin
            r = r ^ poly;
        end
        return (r ^ d) & mask;
    endfunction

endpackage

// File: rtl/misr_compactor.sv
// rtl/misr_compactor.sv - multiple-input signature register with seed load
module misr_compactor
    import bist_pkg::*;
#(
    parameter int               WIDTH = 14,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(MISR_POLY_DEFAULT),
    parameter logic [WIDTH-1:0] SEED  = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= SEED;
        end else if (load) begin
            q <= SEED;
        end else if (en) begin
            q <= WIDTH'(misr_step(32'(q), 32'(d), 32'(POLY), WIDTH));
        end
    end

endmodule

// File: rtl/bist_test_sequencer.sv
// rtl/bist_test_sequencer.sv - applies a ROM test set to a CUT and compacts its responses
module bist_test_sequencer
    import bist_pkg::*;
#(
    parameter int                IN_W       = 15,
    parameter int                OUT_W      = 14,
    parameter int                TEST_COUNT = 148,
    parameter int                ADDR_W     = 8,
    parameter int                RST_CYCLES = 2,
    parameter logic [OUT_W-1:0]  MISR_POLY  = OUT_W'(MISR_POLY_DEFAULT),
    parameter logic [OUT_W-1:0]  MISR_SEED  = '0,
    parameter logic [OUT_W-1:0]  GOLDEN_SIG = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    output logic              vec_rd,
    output logic [ADDR_W-1:0] vec_addr,
    input  logic [IN_W-1:0]   vec_data,
    output logic [IN_W-1:0]   cut_in,
    output logic              cut_clk_en,
    output logic              cut_reset,
    input  logic [OUT_W-1:0]  cut_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [OUT_W-1:0]  signature,
    output logic [ADDR_W-1:0] vec_count
);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] rst_cnt;
    logic              start_ok;
    logic              last_vec;
    logic              rst_last;
    logic              misr_en;

    assign start_ok = start && !abort && (state == IDLE || state == DONE);
    assign last_vec = (vec_count == ADDR_W'(TEST_COUNT - 1));
    assign rst_last = (rst_cnt == ADDR_W'(RST_CYCLES - 1));
    assign misr_en  = (state == CAPTURE) && !abort;

    // CUT controls decode straight from state so an async reset drops them at once.
    assign vec_rd     = (state == FETCH);
    assign cut_reset  = (state == CUT_RST);
    assign cut_clk_en = (state == CUT_RST) || (state == CAPTURE);
    assign busy       = (state == CUT_RST) || (state == FETCH) ||
                        (state == APPLY) || (state == CAPTURE);
    assign done       = (state == DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE, DONE: if (start) state_next = CUT_RST;
                CUT_RST:    if (rst_last) state_next = FETCH;
                FETCH:      state_next = APPLY;
                APPLY:      state_next = CAPTURE;
                CAPTURE:    state_next = last_vec ? DONE : FETCH;
                default:    state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cut_in    <= '0;
            vec_addr  <= '0;
            vec_count <= '0;
            rst_cnt   <= '0;
            pass      <= 1'b0;
        end else if (abort || start_ok) begin
            cut_in    <= '0;
            vec_addr  <= '0;
            vec_count <= '0;
            rst_cnt   <= '0;
            pass      <= 1'b0;
        end else begin
            case (state)
                CUT_RST: rst_cnt <= rst_cnt + 1'b1;
                APPLY:   cut_in  <= vec_data;
                CAPTURE: begin
                    vec_count <= vec_count + 1'b1;
                    // vec_addr is staged here so it is already valid for the next FETCH.
                    if (last_vec) begin
                        pass <= (misr_step(32'(signature), 32'(cut_out), 32'(MISR_POLY), OUT_W)
                                 == 32'(GOLDEN_SIG));
                    end else begin
                        vec_addr <= vec_count + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    misr_compactor #(
        .WIDTH (OUT_W),
        .POLY  (MISR_POLY),
        .SEED  (MISR_SEED)
    ) u_misr (
        .clk   (clk),
        .reset (reset),
        .load  (start_ok),
        .en    (misr_en),
        .d     (cut_out),
        .q     (signature)
    );

endmodule

// File: tb/tb_bist_test_sequencer.sv
// tb/tb_bist_test_sequencer.sv - directed table and sequence checks for bist_test_sequencer
module tb_bist_test_sequencer;

    logic        clk;
    logic        reset;
    logic        start, abort;
    logic        vec_rd;
    logic [7:0]  vec_addr;
    logic [14:0] vec_data;
    logic [14:0] cut_in;
    logic        cut_clk_en, cut_reset;
    logic [13:0] cut_out;
    logic        busy, done, pass;
    logic [13:0] signature;
    logic [7:0]  vec_count;

    logic        start_b;
    logic        vec_rd_b;
    logic [7:0]  vec_addr_b;
    logic [14:0] vec_data_b;
    logic [14:0] cut_in_b;
    logic        cut_clk_en_b, cut_reset_b;
    logic        busy_b, done_b, pass_b;
    logic [13:0] signature_b;
    logic [7:0]  vec_count_b;

    logic [14:0] rom [256];

    int total = 0;
    int bad   = 0;

    bist_test_sequencer #(
        .TEST_COUNT (4),
        .GOLDEN_SIG (14'h0000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .vec_rd     (vec_rd),
        .vec_addr   (vec_addr),
        .vec_data   (vec_data),
        .cut_in     (cut_in),
        .cut_clk_en (cut_clk_en),
        .cut_reset  (cut_reset),
        .cut_out    (cut_out),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .signature  (signature),
        .vec_count  (vec_count)
    );

    bist_test_sequencer #(
        .TEST_COUNT (1),
        .MISR_SEED  (14'h2000),
        .GOLDEN_SIG (14'h2C01)
    ) dut_b (
        .clk        (clk),
        .reset      (reset),
        .start      (start_b),
        .abort      (1'b0),
        .vec_rd     (vec_rd_b),
        .vec_addr   (vec_addr_b),
        .vec_data   (vec_data_b),
        .cut_in     (cut_in_b),
        .cut_clk_en (cut_clk_en_b),
        .cut_reset  (cut_reset_b),
        .cut_out    (14'h0000),
        .busy       (busy_b),
        .done       (done_b),
        .pass       (pass_b),
        .signature  (signature_b),
        .vec_count  (vec_count_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (vec_rd)   vec_data   <= rom[vec_addr];
        if (vec_rd_b) vec_data_b <= rom[vec_addr_b];
    end

    typedef struct {
        logic        start;
        logic [13:0] co;
        logic        busy, done, rd;
        logic [7:0]  addr;
        logic        cen, crst;
        logic [14:0] cin;
        logic [7:0]  cnt;
        logic [13:0] sig;
        logic        pass;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic s, input logic [13:0] co, input logic b, input logic d,
                       input logic r, input logic [7:0] ad, input logic ce, input logic cr,
                       input logic [14:0] ci, input logic [7:0] cn, input logic [13:0] sg,
                       input logic p);
        vec_t v;
        v.start = s; v.co = co; v.busy = b; v.done = d; v.rd = r; v.addr = ad;
        v.cen = ce; v.crst = cr; v.cin = ci; v.cnt = cn; v.sig = sg; v.pass = p;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic run_a(input int inject, output int n);
        int g;
        n = 0;
        g = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (!done && g < 100) begin
            if (busy) n++;
            start = (g == inject);
            tick();
            g++;
        end
        start = 1'b0;
        chk("run reached done", 32'(done), 32'd1);
    endtask

    initial begin
        int n;
        int g;
        reset = 1'b0; start = 1'b0; abort = 1'b0; start_b = 1'b0; cut_out = '0;
        vec_data = '0; vec_data_b = '0;
        for (int k = 0; k < 256; k++) rom[k] = 15'(k + 1);

        // Non-capture rows drive 3FFF on cut_out so any stray MISR update shows.
        //   start co        busy done rd addr cen crst cin cnt sig       pass
        add(1, 14'h3FFF, 0, 0, 0, 0, 0, 0, 0, 0, 14'h0000, 0);
        add(0, 14'h3FFF, 1, 0, 0, 0, 1, 1, 0, 0, 14'h0000, 0);
        add(0, 14'h3FFF, 1, 0, 0, 0, 1, 1, 0, 0, 14'h0000, 0);
        add(0, 14'h3FFF, 1, 0, 1, 0, 0, 0, 0, 0, 14'h0000, 0);
        add(0, 14'h3FFF, 1, 0, 0, 0, 0, 0, 0, 0, 14'h0000, 0);
        add(0, 14'h2000, 1, 0, 0, 0, 1, 0, 1, 0, 14'h0000, 0);
        add(0, 14'h3FFF, 1, 0, 1, 1, 0, 0, 1, 1, 14'h2000, 0);
        add(0, 14'h3FFF, 1, 0, 0, 1, 0, 0, 1, 1, 14'h2000, 0);
        add(0, 14'h0000, 1, 0, 0, 1, 1, 0, 2, 1, 14'h2000, 0);
        add(0, 14'h3FFF, 1, 0, 1, 2, 0, 0, 2, 2, 14'h2C01, 0);
        add(0, 14'h3FFF, 1, 0, 0, 2, 0, 0, 2, 2, 14'h2C01, 0);
        add(0, 14'h0005, 1, 0, 0, 2, 1, 0, 3, 2, 14'h2C01, 0);
        add(0, 14'h3FFF, 1, 0, 1, 3, 0, 0, 3, 3, 14'h3406, 0);
        add(0, 14'h3FFF, 1, 0, 0, 3, 0, 0, 3, 3, 14'h3406, 0);
        add(0, 14'h0000, 1, 0, 0, 3, 1, 0, 4, 3, 14'h3406, 0);
        add(0, 14'h3FFF, 0, 1, 0, 3, 0, 0, 4, 4, 14'h040D, 0);
        add(0, 14'h3FFF, 0, 1, 0, 3, 0, 0, 4, 4, 14'h040D, 0);

        repeat (2) tick();
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset pass", 32'(pass), 32'd0);
        chk("reset vec_rd", 32'(vec_rd), 32'd0);
        chk("reset cut_clk_en", 32'(cut_clk_en), 32'd0);
        chk("reset cut_reset", 32'(cut_reset), 32'd0);
        chk("reset cut_in", 32'(cut_in), 32'd0);
        chk("reset vec_addr", 32'(vec_addr), 32'd0);
        chk("reset vec_count", 32'(vec_count), 32'd0);
        chk("reset signature", 32'(signature), 32'd0);
        chk("reset seed b", 32'(signature_b), 32'h2000);
        reset = 1'b1;
        tick();

        foreach (tbl[i]) begin
            chk($sformatf("row%0d busy", i), 32'(busy), 32'(tbl[i].busy));
            chk($sformatf("row%0d done", i), 32'(done), 32'(tbl[i].done));
            chk($sformatf("row%0d vec_rd", i), 32'(vec_rd), 32'(tbl[i].rd));
            chk($sformatf("row%0d vec_addr", i), 32'(vec_addr), 32'(tbl[i].addr));
            chk($sformatf("row%0d cut_clk_en", i), 32'(cut_clk_en), 32'(tbl[i].cen));
            chk($sformatf("row%0d cut_reset", i), 32'(cut_reset), 32'(tbl[i].crst));
            chk($sformatf("row%0d cut_in", i), 32'(cut_in), 32'(tbl[i].cin));
            chk($sformatf("row%0d vec_count", i), 32'(vec_count), 32'(tbl[i].cnt));
            chk($sformatf("row%0d signature", i), 32'(signature), 32'(tbl[i].sig));
            chk($sformatf("row%0d pass", i), 32'(pass), 32'(tbl[i].pass));
            start   = tbl[i].start;
            cut_out = tbl[i].co;
            tick();
        end
        start = 1'b0;

        // Single-vector run exercising MISR feedback from seed 2000.
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        n = 0;
        g = 0;
        while (!done_b && g < 50) begin
            if (busy_b) n++;
            tick();
            g++;
        end
        chk("b done", 32'(done_b), 32'd1);
        chk("b run length", 32'(n), 32'd5);
        chk("b signature", 32'(signature_b), 32'h2C01);
        chk("b pass", 32'(pass_b), 32'd1);
        chk("b vec_count", 32'(vec_count_b), 32'd1);
        chk("b cut_in", 32'(cut_in_b), 32'd1);
        chk("b cut_clk_en", 32'(cut_clk_en_b), 32'd0);
        chk("b cut_reset", 32'(cut_reset_b), 32'd0);

        // Compaction with constant cut_out=1, restarted from DONE.
        cut_out = 14'h0001;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("cmp reload", 32'(signature), 32'd0);
        repeat (5) tick();
        chk("cmp sig after cap1", 32'(signature), 32'h0001);
        repeat (3) tick();
        chk("cmp sig after cap2", 32'(signature), 32'h0003);
        repeat (6) tick();
        chk("cmp done", 32'(done), 32'd1);
        chk("cmp final sig", 32'(signature), 32'h000F);
        chk("cmp pass", 32'(pass), 32'd0);
        chk("cmp vec_count", 32'(vec_count), 32'd4);

        // Abort during the second APPLY, then abort+start together, then a full rerun.
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("abt reload", 32'(signature), 32'd0);
        repeat (6) tick();
        chk("abt in apply busy", 32'(busy), 32'd1);
        chk("abt in apply sig", 32'(signature), 32'h0001);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abt busy", 32'(busy), 32'd0);
        chk("abt done", 32'(done), 32'd0);
        chk("abt sig held", 32'(signature), 32'h0001);
        chk("abt vec_count", 32'(vec_count), 32'd0);
        chk("abt cut_in", 32'(cut_in), 32'd0);
        chk("abt vec_addr", 32'(vec_addr), 32'd0);
        chk("abt cut_clk_en", 32'(cut_clk_en), 32'd0);
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        chk("abt+start busy", 32'(busy), 32'd0);
        chk("abt+start sig", 32'(signature), 32'h0001);
        run_a(5, n);
        chk("rerun length", 32'(n), 32'd14);
        chk("rerun sig", 32'(signature), 32'h000F);
        chk("rerun vec_count", 32'(vec_count), 32'd4);

        // Asynchronous reset in the low phase of the second CAPTURE.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        chk("ar capture cen", 32'(cut_clk_en), 32'd1);
        chk("ar capture sig", 32'(signature), 32'h0001);
        #2;
        reset = 1'b0;
        #1;
        chk("ar busy", 32'(busy), 32'd0);
        chk("ar done", 32'(done), 32'd0);
        chk("ar cut_clk_en", 32'(cut_clk_en), 32'd0);
        chk("ar cut_reset", 32'(cut_reset), 32'd0);
        chk("ar vec_rd", 32'(vec_rd), 32'd0);
        chk("ar signature", 32'(signature), 32'd0);
        chk("ar vec_count", 32'(vec_count), 32'd0);
        chk("ar cut_in", 32'(cut_in), 32'd0);
        chk("ar vec_addr", 32'(vec_addr), 32'd0);
        chk("ar pass", 32'(pass), 32'd0);
        start = 1'b1;
        tick();
        tick();
        chk("ar start ignored", 32'(busy), 32'd0);
        start = 1'b0;
        reset = 1'b1;
        tick();
        chk("ar idle after release", 32'(busy), 32'd0);
        cut_out = 14'h0000;
        run_a(-1, n);
        chk("zero run length", 32'(n), 32'd14);
        chk("zero run sig", 32'(signature), 32'd0);
        chk("zero run pass", 32'(pass), 32'd1);
        chk("zero run vec_count", 32'(vec_count), 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
